// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences
// multi-cycle EX ops, issues exception flush and counts stall cycles.
module pipe_ctrl #(
  parameter int MC_LATENCY = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_mem,
  input  logic             mc_req,
  input  logic             mc_zero,
  input  logic             exc_valid,
  input  logic [31:0]      exc_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int CW =
    (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(MC_LATENCY - 1);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ex_req;

  // Exception redirect; everything is held quiet during reset.
  always_comb begin
    flush  = 1'b0;
    new_pc = '0;
    if (!rst && exc_valid) begin
      flush  = 1'b1;
      new_pc = exc_pc;
    end
  end

  // EX asks for a stall until the multi-cycle result is ready.
  always_comb begin
    ex_req  = 1'b0;
    mc_done = 1'b0;
    if (!rst) begin
      ex_req  = mc_req && (state != DONE);
      mc_done = (state == DONE) && !exc_valid;
    end
  end

  assign mc_busy = ex_req;

  // Deepest request wins; a flush cancels every stall.
  always_comb begin
    stall = STALL_NONE;
    priority case (1'b1)
      rst:          stall = STALL_NONE;
      flush:        stall = STALL_NONE;
      stallreq_mem: stall = STALL_MEM;
      ex_req:       stall = STALL_EX;
      stallreq_id:  stall = STALL_ID;
      stallreq_if:  stall = STALL_IF;
      default:      stall = STALL_NONE;
    endcase
  end

  // Multi-cycle sequencer: count down RUN cycles, then hold
  // the result in DONE until the MEM stage can accept it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (exc_valid) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mc_req) begin
            if (mc_zero) begin
              state <= DONE;
            end else begin
              state <= RUN;
              cnt   <= CNT_LOAD;
            end
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!stall[3]) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall[0] && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: the driver queues the expected
// outputs of each cycle, a monitor pops and compares them.
module tb_pipe_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stallreq_if = 1'b1;
  logic          stallreq_id = 1'b1;
  logic          stallreq_mem = 1'b1;
  logic          mc_req = 1'b1;
  logic          mc_zero = 1'b1;
  logic          exc_valid = 1'b1;
  logic [31:0]   exc_pc = 32'h8000_0180;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic          mc_busy;
  logic          mc_done;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl #(
    .MC_LATENCY(LAT),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_if (stallreq_if),
    .stallreq_id (stallreq_id),
    .stallreq_mem(stallreq_mem),
    .mc_req      (mc_req),
    .mc_zero     (mc_zero),
    .exc_valid   (exc_valid),
    .exc_pc      (exc_pc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .mc_busy     (mc_busy),
    .mc_done     (mc_done),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   pc;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  int   vid    = 0;
  bit   drv_done = 1'b0;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL v%0d %s got %0h expected %0h",
                  id, nm, got, want);
  endtask

  // One cycle of stimulus, driven just after the edge, plus the
  // hand-computed outputs for that cycle. stall_cnt is the
  // registered value entering the cycle.
  task automatic cyc(input logic r, fi, di, mm, mq, mz, xv,
                     input logic [5:0] es,
                     input logic eb, ed,
                     input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    stallreq_if  = fi;
    stallreq_id  = di;
    stallreq_mem = mm;
    mc_req       = mq;
    mc_zero      = mz;
    exc_valid    = xv;
    e.id    = vid;
    e.stall = es;
    e.flush = xv && !r;
    e.pc    = (xv && !r) ? exc_pc : 32'h0;
    e.busy  = eb;
    e.done  = ed;
    e.cnt   = CW'(ec);
    exp_q.push_back(e);
    vid++;
  endtask

  // Monitor: outputs are settled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", e.id, 32'(stall), 32'(e.stall));
      chk("flush", e.id, 32'(flush), 32'(e.flush));
      chk("new_pc", e.id, new_pc, e.pc);
      chk("mc_busy", e.id, 32'(mc_busy), 32'(e.busy));
      chk("mc_done", e.id, 32'(mc_done), 32'(e.done));
      chk("stall_cnt", e.id, 32'(stall_cnt), 32'(e.cnt));
    end
  end

  // Only a flush or reset may take mc_req away from a running op.
  logic p_busy = 1'b0;
  logic p_flush = 1'b0;
  logic p_rst = 1'b1;
  always @(negedge clk) begin
    assert (!(!rst && !p_rst && p_busy && !p_flush &&
              !mc_req && !exc_valid && !mc_done))
      else $error("mc_req dropped during multi-cycle op");
    p_busy  <= mc_busy;
    p_flush <= flush;
    p_rst   <= rst;
  end

  initial begin
    // reset with every request asserted
    cyc(1,1,1,1,1,1,1, 6'h00, 0,0, 0);
    cyc(1,1,1,1,1,1,1, 6'h00, 0,0, 0);
    cyc(0,0,0,0,0,0,0, 6'h00, 0,0, 0);
    // ID beats IF, then IF alone
    cyc(0,1,1,0,0,0,0, 6'h07, 0,0, 0);
    cyc(0,1,0,0,0,0,0, 6'h03, 0,0, 1);
    cyc(0,0,0,0,0,0,0, 6'h00, 0,0, 2);
    // full-latency op
    cyc(0,0,0,0,1,0,0, 6'h0F, 1,0, 2);
    for (int i = 0; i < LAT; i++)
      cyc(0,0,0,0,1,0,0, 6'h0F, 1,0, 3 + i);
    cyc(0,0,0,0,1,0,0, 6'h00, 0,1, 7);
    cyc(0,0,0,0,0,0,0, 6'h00, 0,0, 7);
    // zero-latency op
    cyc(0,0,0,0,1,1,0, 6'h0F, 1,0, 7);
    cyc(0,0,0,0,1,0,0, 6'h00, 0,1, 8);
    cyc(0,0,0,0,0,0,0, 6'h00, 0,0, 8);
    // MEM stall holds the result in DONE
    cyc(1,0,0,0,0,0,0, 6'h00, 0,0, 8);
    cyc(0,0,0,0,1,0,0, 6'h0F, 1,0, 0);
    for (int i = 0; i < LAT; i++)
      cyc(0,0,0,0,1,0,0, 6'h0F, 1,0, 1 + i);
    for (int i = 0; i < 3; i++)
      cyc(0,0,0,1,1,0,0, 6'h1F, 0,1, 5 + i);
    cyc(0,0,0,0,1,0,0, 6'h00, 0,1, 8);
    cyc(0,0,0,0,0,0,0, 6'h00, 0,0, 8);
    // flush mid-RUN beats a MEM stall, then FSM is IDLE
    cyc(0,0,0,0,1,0,0, 6'h0F, 1,0, 8);
    cyc(0,0,0,0,1,0,0, 6'h0F, 1,0, 9);
    cyc(0,0,0,1,0,0,1, 6'h00, 0,0, 10);
    cyc(0,0,0,0,0,0,0, 6'h00, 0,0, 10);
    cyc(0,0,0,0,1,1,0, 6'h0F, 1,0, 10);
    cyc(0,0,0,0,1,0,0, 6'h00, 0,1, 11);
    cyc(0,0,0,0,0,0,0, 6'h00, 0,0, 11);
    // counter saturation
    cyc(1,0,0,0,0,0,0, 6'h00, 0,0, 11);
    for (int i = 0; i < 20; i++)
      cyc(0,0,0,1,0,0,0, 6'h1F, 0,0, (i > 15) ? 15 : i);
    cyc(0,0,0,0,0,0,0, 6'h00, 0,0, 15);
    // reset in the middle of RUN
    cyc(0,0,0,0,1,0,0, 6'h0F, 1,0, 15);
    cyc(0,0,0,0,1,0,0, 6'h0F, 1,0, 15);
    cyc(1,0,0,0,1,0,0, 6'h00, 0,0, 15);
    cyc(0,0,0,0,0,0,0, 6'h00, 0,0, 0);
    cyc(0,0,0,0,1,1,0, 6'h0F, 1,0, 0);
    cyc(0,0,0,0,1,0,0, 6'h00, 0,1, 1);
    cyc(0,0,0,0,0,0,0, 6'h00, 0,0, 1);
    drv_done = 1'b1;
  end

  initial begin
    int left;
    wait (drv_done);
    repeat (3) @(posedge clk);
    left = exp_q.size();
    chk("queue_drain", vid, 32'(left), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got %0d/%0d expected done",
             passed, total);
    $fatal(1, "bench timeout");
  end

endmodule
